issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/issue_ctrl_scoreboard.sv | 78 +++++++
 rtl/issue_ctrl.sv | 99 +++++++++
 tb/tb_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and issue-stage payload type.
// Widths here fix the decode/issue/execute interface for the whole core.
package riscv_pkg;
   localparam int XLEN             = 32;
   localparam int NB_REG           = 32;
   localparam int NB_UNIT          = 4;
   localparam int NB_OPERATION     = 8;
   localparam int MAX_INFLIGHT_DEF = 4;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic                    rd_v;
      logic [4:0]              rd;
      logic [4:0]              rs1;
      logic [4:0]              rs2;
      logic [NB_UNIT-1:0]      unit;
      logic [NB_OPERATION-1:0] operation;
   } issue_pld_t;

   // x0 is hardwired zero, so it never maps onto a scoreboard bit.
   function automatic logic [NB_REG-1:0] reg_mask(input logic v, input logic [4:0] adr);
      logic [NB_REG-1:0] m;
      m = '0;
      if (v && adr != 5'd0) m[adr] = 1'b1;
      return m;
   endfunction
endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Register scoreboard: pending bitmap, outstanding-writer count, hazard and limit lookup.
// Lookups are combinational; bitmap/count update on the next edge, flush clears both.
module scoreboard
   import riscv_pkg::*;
#(
   parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_i,
   input  logic              set_v_i,
   input  logic [4:0]        set_rd_i,
   input  logic              wb_valid_i,
   input  logic [4:0]        wb_rd_i,
   input  logic              entry_busy_v_i,
   input  logic              entry_cnt_v_i,
   input  logic [4:0]        entry_rd_i,
   input  logic              rs1_v_i,
   input  logic [4:0]        rs1_i,
   input  logic              rs2_v_i,
   input  logic [4:0]        rs2_i,
   input  logic              rd_v_i,
   input  logic [4:0]        rd_i,
   output logic              hazard_o,
   output logic              limit_o,
   output logic [NB_REG-1:0] pending_o,
   output logic [CNT_W-1:0]  inflight_o
);
   logic [NB_REG-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]  inflight_q, inflight_d;

   logic [NB_REG-1:0] wb_mask, clr_mask, set_mask, after_clr, busy;
   logic              inc, dec, counted, entry_cnt;
   logic [CNT_W:0]    load_sum;

   always_comb begin
      wb_mask   = reg_mask(wb_valid_i, wb_rd_i);
      clr_mask  = wb_mask & pending_q;
      set_mask  = reg_mask(set_v_i, set_rd_i);
      after_clr = pending_q & ~clr_mask;

      busy     = (pending_q & ~wb_mask) | reg_mask(entry_busy_v_i, entry_rd_i);
      hazard_o = |(busy & reg_mask(rs1_v_i, rs1_i))
               | |(busy & reg_mask(rs2_v_i, rs2_i))
               | |(busy & reg_mask(rd_v_i, rd_i));

      // The entry still in the issue register has not reached the count yet.
      counted   = |reg_mask(rd_v_i, rd_i);
      entry_cnt = |reg_mask(entry_cnt_v_i, entry_rd_i);
      load_sum  = {1'b0, inflight_q} + (CNT_W + 1)'(entry_cnt);
      limit_o   = counted && (load_sum >= (CNT_W + 1)'(MAX_INFLIGHT));

      // A set landing on a bit cleared this cycle counts as +1 -1, so set wins.
      inc = |(set_mask & ~after_clr);
      dec = |clr_mask;

      pending_d  = after_clr | set_mask;
      inflight_d = inflight_q + CNT_W'(inc) - CNT_W'(dec);
      if (flush_i) begin
         pending_d  = '0;
         inflight_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q  <= '0;
         inflight_q <= '0;
      end else begin
         pending_q  <= pending_d;
         inflight_q <= inflight_d;
      end
   end

   assign pending_o  = pending_q;
   assign inflight_o = inflight_q;
endmodule

// File: rtl/issue_ctrl.sv
// One-entry issue register between decode and execute, gated by the scoreboard.
// Payload valid one cycle after accept; load and drain overlap, stalled entry holds.
module issue_ctrl
   import riscv_pkg::*;
#(
   parameter  int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
   localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dec_valid_i,
   output logic                    dec_ready_o,
   input  logic                    dec_rd_v_i,
   input  logic [4:0]              dec_rd_i,
   input  logic                    dec_rs1_v_i,
   input  logic [4:0]              dec_rs1_adr_i,
   input  logic                    dec_rs2_v_i,
   input  logic [4:0]              dec_rs2_adr_i,
   input  logic [NB_UNIT-1:0]      dec_unit_i,
   input  logic [NB_OPERATION-1:0] dec_operation_i,
   output logic                    issue_valid_o,
   input  logic                    issue_ready_i,
   output logic                    issue_rd_v_o,
   output logic [4:0]              issue_rd_o,
   output logic [4:0]              issue_rs1_adr_o,
   output logic [4:0]              issue_rs2_adr_o,
   output logic [NB_UNIT-1:0]      issue_unit_o,
   output logic [NB_OPERATION-1:0] issue_operation_o,
   input  logic                    wb_valid_i,
   input  logic [4:0]              wb_rd_i,
   input  logic                    flush_i,
   output logic [NB_REG-1:0]       pending_o,
   output logic [CNT_W-1:0]        inflight_o
);
   issue_pld_t pld_q, pld_d;
   logic       issue_valid_q, issue_valid_d;
   logic       drain, load, hazard, limit;

   assign drain       = issue_valid_q & issue_ready_i;
   assign dec_ready_o = ~flush_i & ~reset & ~hazard & ~limit & (~issue_valid_q | issue_ready_i);
   assign load        = dec_valid_i & dec_ready_o;

   always_comb begin
      issue_valid_d = issue_valid_q;
      pld_d         = pld_q;
      if (load) begin
         issue_valid_d = 1'b1;
         pld_d = '{rd_v: dec_rd_v_i, rd: dec_rd_i, rs1: dec_rs1_adr_i, rs2: dec_rs2_adr_i,
                   unit: dec_unit_i, operation: dec_operation_i};
      end else if (drain) begin
         issue_valid_d = 1'b0;
      end
      if (flush_i) issue_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         issue_valid_q <= 1'b0;
         pld_q         <= '0;
      end else begin
         issue_valid_q <= issue_valid_d;
         pld_q         <= pld_d;
      end
   end

   scoreboard #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
   ) u_scoreboard (
      .clk            (clk),
      .reset          (reset),
      .flush_i        (flush_i),
      .set_v_i        (drain & pld_q.rd_v),
      .set_rd_i       (pld_q.rd),
      .wb_valid_i     (wb_valid_i),
      .wb_rd_i        (wb_rd_i),
      .entry_busy_v_i (issue_valid_q & pld_q.rd_v & ~drain),
      .entry_cnt_v_i  (issue_valid_q & pld_q.rd_v),
      .entry_rd_i     (pld_q.rd),
      .rs1_v_i        (dec_rs1_v_i),
      .rs1_i          (dec_rs1_adr_i),
      .rs2_v_i        (dec_rs2_v_i),
      .rs2_i          (dec_rs2_adr_i),
      .rd_v_i         (dec_rd_v_i),
      .rd_i           (dec_rd_i),
      .hazard_o       (hazard),
      .limit_o        (limit),
      .pending_o      (pending_o),
      .inflight_o     (inflight_o)
   );

   assign issue_valid_o     = issue_valid_q;
   assign issue_rd_v_o      = pld_q.rd_v;
   assign issue_rd_o        = pld_q.rd;
   assign issue_rs1_adr_o   = pld_q.rs1;
   assign issue_rs2_adr_o   = pld_q.rs2;
   assign issue_unit_o      = pld_q.unit;
   assign issue_operation_o = pld_q.operation;
endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural scoreboard/issue model.
module tb_issue_ctrl;
   import riscv_pkg::*;

   localparam int MAXI = 4;
   localparam int CW   = $clog2(MAXI + 1);

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    dec_valid_i, dec_ready_o;
   logic                    dec_rd_v_i, dec_rs1_v_i, dec_rs2_v_i;
   logic [4:0]              dec_rd_i, dec_rs1_adr_i, dec_rs2_adr_i;
   logic [NB_UNIT-1:0]      dec_unit_i;
   logic [NB_OPERATION-1:0] dec_operation_i;
   logic                    issue_valid_o, issue_ready_i, issue_rd_v_o;
   logic [4:0]              issue_rd_o, issue_rs1_adr_o, issue_rs2_adr_o;
   logic [NB_UNIT-1:0]      issue_unit_o;
   logic [NB_OPERATION-1:0] issue_operation_o;
   logic                    wb_valid_i, flush_i;
   logic [4:0]              wb_rd_i;
   logic [31:0]             pending_o;
   logic [CW-1:0]           inflight_o;

   always #5 clk = ~clk;

   issue_ctrl #(.MAX_INFLIGHT(MAXI)) dut (
      .clk(clk), .reset(reset),
      .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
      .dec_rd_v_i(dec_rd_v_i), .dec_rd_i(dec_rd_i),
      .dec_rs1_v_i(dec_rs1_v_i), .dec_rs1_adr_i(dec_rs1_adr_i),
      .dec_rs2_v_i(dec_rs2_v_i), .dec_rs2_adr_i(dec_rs2_adr_i),
      .dec_unit_i(dec_unit_i), .dec_operation_i(dec_operation_i),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
      .issue_rd_v_o(issue_rd_v_o), .issue_rd_o(issue_rd_o),
      .issue_rs1_adr_o(issue_rs1_adr_o), .issue_rs2_adr_o(issue_rs2_adr_o),
      .issue_unit_o(issue_unit_o), .issue_operation_o(issue_operation_o),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
      .pending_o(pending_o), .inflight_o(inflight_o)
   );

   int total = 0;
   int bad   = 0;

   // Model: set of registers awaiting writeback plus the single held instruction.
   bit         m_known = 0;
   bit         m_valid;
   bit [31:0]  m_pend;
   issue_pld_t m_pl;
   bit         last_rdy;
   issue_pld_t last_pl;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic issue_pld_t dut_pl();
      return '{rd_v: issue_rd_v_o, rd: issue_rd_o, rs1: issue_rs1_adr_o, rs2: issue_rs2_adr_o,
               unit: issue_unit_o, operation: issue_operation_o};
   endfunction

   function automatic bit model_ready();
      bit [31:0] busy;
      bit        draining, haz, lim;
      int        outstanding;
      draining = m_valid && issue_ready_i;
      busy = m_pend;
      if (wb_valid_i) busy[wb_rd_i] = 1'b0;
      if (m_valid && m_pl.rd_v && !draining) busy[m_pl.rd] = 1'b1;
      busy[0] = 1'b0;
      haz = (dec_rs1_v_i && busy[dec_rs1_adr_i]) || (dec_rs2_v_i && busy[dec_rs2_adr_i])
         || (dec_rd_v_i && busy[dec_rd_i]);
      outstanding = $countones(m_pend) + ((m_valid && m_pl.rd_v && m_pl.rd != 0) ? 1 : 0);
      lim = dec_rd_v_i && dec_rd_i != 0 && outstanding >= MAXI;
      return !flush_i && !reset && !haz && !lim && (!m_valid || issue_ready_i);
   endfunction

   task automatic compare_all();
      if (!m_known) return;
      chk("dec_ready", {31'd0, dec_ready_o}, {31'd0, model_ready()});
      chk("issue_valid", {31'd0, issue_valid_o}, {31'd0, m_valid});
      chk("pending", pending_o, m_pend);
      chk("inflight", 32'(inflight_o), 32'($countones(m_pend)));
      chk("inflight_bound", {31'd0, (int'(inflight_o) <= MAXI)}, 32'd1);
      if (m_valid) chk("payload", 32'(dut_pl()), 32'(m_pl));
   endtask

   task automatic model_update();
      bit rdy, draining;
      rdy = model_ready();
      if (reset) begin
         m_known = 1; m_valid = 0; m_pend = '0; m_pl = '0;
      end else if (!m_known) begin
      end else if (flush_i) begin
         m_valid = 0; m_pend = '0;
      end else begin
         draining = m_valid && issue_ready_i;
         if (wb_valid_i) m_pend[wb_rd_i] = 1'b0;
         if (draining && m_pl.rd_v && m_pl.rd != 0) m_pend[m_pl.rd] = 1'b1;
         if (dec_valid_i && rdy) begin
            m_valid = 1;
            m_pl = '{rd_v: dec_rd_v_i, rd: dec_rd_i, rs1: dec_rs1_adr_i, rs2: dec_rs2_adr_i,
                     unit: dec_unit_i, operation: dec_operation_i};
         end else if (draining) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      last_rdy = dec_ready_o;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_dec(input bit v, input bit rdv, input int rd, input bit r1v, input int r1,
                          input bit r2v, input int r2);
      dec_valid_i = v;  dec_rd_v_i = rdv; dec_rd_i = 5'(rd);
      dec_rs1_v_i = r1v; dec_rs1_adr_i = 5'(r1);
      dec_rs2_v_i = r2v; dec_rs2_adr_i = 5'(r2);
      dec_unit_i = '0; dec_unit_i[$urandom_range(NB_UNIT-1, 0)] = 1'b1;
      dec_operation_i = '0; dec_operation_i[$urandom_range(NB_OPERATION-1, 0)] = 1'b1;
      last_pl = '{rd_v: rdv, rd: 5'(rd), rs1: 5'(r1), rs2: 5'(r2), unit: dec_unit_i,
                  operation: dec_operation_i};
   endtask

   task automatic idle();
      set_dec(0, 0, 0, 0, 0, 0, 0);
      wb_valid_i = 0; wb_rd_i = '0; flush_i = 0; reset = 0;
   endtask

   task automatic push(input string nm, input int max);
      int n = 0;
      do begin step(); n++; end while (!last_rdy && n < max);
      chk({nm, "_accept"}, {31'd0, last_rdy}, 32'd1);
      dec_valid_i = 0;
   endtask

   task automatic clean();
      flush_i = 1; step(); flush_i = 0;
   endtask

   task automatic fill_f0_with_entry();
      clean();
      issue_ready_i = 1;
      for (int k = 4; k <= 7; k++) begin set_dec(1, 1, k, 0, 0, 0, 0); push("f0_wr", 4); end
      set_dec(1, 0, 8, 1, 2, 0, 0); push("f0_nowr", 4);
      issue_ready_i = 0; idle();
      step();
      chk("pre_pend_f0", pending_o, 32'hF0);
      chk("pre_entry_valid", {31'd0, issue_valid_o}, 32'd1);
   endtask

   initial begin
      issue_pld_t x_pl, y_pl;
      idle(); issue_ready_i = 0;
      reset = 1;
      set_dec(1, 1, 3, 0, 0, 0, 0);
      step(); step();
      chk("rst_valid", {31'd0, issue_valid_o}, 32'd0);
      chk("rst_pending", pending_o, 32'd0);
      chk("rst_inflight", 32'(inflight_o), 32'd0);
      chk("rst_payload", 32'(dut_pl()), 32'd0);
      chk("rst_ready", {31'd0, dec_ready_o}, 32'd0);
      idle();

      // RAW stall released in the writeback cycle.
      issue_ready_i = 1;
      set_dec(1, 1, 5, 0, 0, 0, 0); push("add5", 4);
      idle(); step();
      chk("raw_pend5", pending_o, 32'h20);
      set_dec(1, 1, 6, 1, 5, 0, 0); #1;
      chk("raw_stall0", {31'd0, dec_ready_o}, 32'd0);
      step(); step();
      chk("raw_stall2", {31'd0, dec_ready_o}, 32'd0);
      wb_valid_i = 1; wb_rd_i = 5; #1;
      chk("raw_wb_accept", {31'd0, dec_ready_o}, 32'd1);
      step(); idle();
      chk("raw_loaded_rd", 32'(issue_rd_o), 32'd6);
      step();
      chk("raw_pend6", pending_o, 32'h40);
      chk("raw_inflight", 32'(inflight_o), 32'd1);

      // In-flight limit.
      clean(); issue_ready_i = 1;
      for (int k = 1; k <= 4; k++) begin set_dec(1, 1, k, 0, 0, 0, 0); push("lim_wr", 4); end
      set_dec(1, 1, 6, 0, 0, 0, 0);
      step(); chk("lim_stall_drain", {31'd0, last_rdy}, 32'd0);
      step(); chk("lim_stall_full", {31'd0, last_rdy}, 32'd0);
      chk("lim_inflight4", 32'(inflight_o), 32'd4);
      chk("lim_pend", pending_o, 32'h1E);
      wb_valid_i = 1; wb_rd_i = 2; step(); wb_valid_i = 0;
      push("lim_x6", 3);
      idle(); step();
      chk("lim_inflight_after", 32'(inflight_o), 32'd4);
      chk("lim_pend_after", pending_o, 32'h5A);

      // x0 destination/source while full: no stall, no count.
      set_dec(1, 1, 0, 1, 0, 0, 0); #1;
      chk("x0_ready_full", {31'd0, dec_ready_o}, 32'd1);
      step(); idle(); step();
      chk("x0_pend", pending_o, 32'h5A);
      chk("x0_inflight", 32'(inflight_o), 32'd4);

      // Backpressure holds the payload.
      clean(); issue_ready_i = 0;
      set_dec(1, 1, 9, 1, 3, 0, 0); x_pl = last_pl; push("bp_x", 4);
      set_dec(1, 1, 10, 1, 11, 1, 12); y_pl = last_pl;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_ready", {31'd0, dec_ready_o}, 32'd0);
         chk("bp_payload", 32'(dut_pl()), 32'(x_pl));
         step();
      end
      issue_ready_i = 1; #1;
      chk("bp_release_ready", {31'd0, dec_ready_o}, 32'd1);
      step(); idle();
      chk("bp_new_payload", 32'(dut_pl()), 32'(y_pl));
      chk("bp_new_valid", {31'd0, issue_valid_o}, 32'd1);

      // Drain re-writing x7 coincides with writeback of x7.
      clean(); issue_ready_i = 0;
      set_dec(1, 1, 7, 0, 0, 0, 0); push("w7a", 4);
      set_dec(1, 1, 7, 0, 0, 0, 0); issue_ready_i = 1; #1;
      chk("w7_window_ready", {31'd0, dec_ready_o}, 32'd1);
      step(); idle();
      chk("w7_pend_before", pending_o, 32'h80);
      chk("w7_inflight_before", 32'(inflight_o), 32'd1);
      wb_valid_i = 1; wb_rd_i = 7; step(); wb_valid_i = 0;
      chk("w7_pend_after", {31'd0, pending_o[7]}, 32'd1);
      chk("w7_inflight_after", 32'(inflight_o), 32'd1);

      // Flush, then reset, over a valid entry and pending 0xF0.
      fill_f0_with_entry();
      flush_i = 1; set_dec(1, 0, 0, 0, 0, 0, 0); #1;
      chk("flush_ready", {31'd0, dec_ready_o}, 32'd0);
      step(); idle();
      chk("flush_valid", {31'd0, issue_valid_o}, 32'd0);
      chk("flush_pend", pending_o, 32'd0);
      chk("flush_inflight", 32'(inflight_o), 32'd0);
      fill_f0_with_entry();
      reset = 1; issue_ready_i = 1; set_dec(1, 0, 0, 0, 0, 0, 0); #1;
      chk("reset_ready", {31'd0, dec_ready_o}, 32'd0);
      step(); idle();
      chk("reset_valid", {31'd0, issue_valid_o}, 32'd0);
      chk("reset_pend", pending_o, 32'd0);
      chk("reset_inflight", 32'(inflight_o), 32'd0);
      chk("reset_payload", 32'(dut_pl()), 32'd0);

      // Random traffic over a small register window to provoke hazards.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         set_dec($urandom_range(9, 0) < 7, $urandom_range(3, 0) != 0, $urandom_range(7, 0),
                 $urandom_range(1, 0) == 1, $urandom_range(7, 0),
                 $urandom_range(1, 0) == 1, $urandom_range(7, 0));
         issue_ready_i = $urandom_range(9, 0) < 7;
         wb_valid_i    = $urandom_range(9, 0) < 4;
         wb_rd_i       = 5'($urandom_range(7, 0));
         if (m_pend != 0 && $urandom_range(1, 0) == 1)
            for (int r = 1; r < 8; r++)
               if (m_pend[r] && $urandom_range(2, 0) == 0) wb_rd_i = 5'(r);
         flush_i = $urandom_range(59, 0) == 0;
         reset   = $urandom_range(199, 0) == 0;
         step();
      end
      idle(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
